mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU data port and debug/loader port share one memory.
// CPU has priority; the debug port is guaranteed a slot after STARVE_LIMIT CPU grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  state_t        r_state;
  owner_t        r_owner;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_cpu_rdata;
  logic [31:0]   r_dbg_rdata;
  logic [SW-1:0] r_starve_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic          r_err;

  logic w_dbg_win;
  logic w_any_req;

  // Debug wins when alone, or when the CPU has used up its consecutive-grant budget.
  assign w_dbg_win = dbg_req && (!cpu_req || (r_starve_cnt == STARVE_MAX));
  assign w_any_req = cpu_req || dbg_req;

  // NOTE: every next-state term is a registered value or a continuous assign, so no
  // always_comb exists that could leave a signal unassigned and infer a latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; a later assignment in the case below
      // overrides this default clear within the same cycle.
      if (!dbg_req) r_starve_cnt <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state    <= ACCESS;
            r_wait_cnt <= '0;
            if (w_dbg_win) begin
              r_owner      <= OWN_DBG;
              r_we         <= dbg_we;
              r_addr       <= dbg_addr & ~32'h3;
              r_wdata      <= dbg_wdata;
              r_starve_cnt <= '0;
            end else begin
              r_owner <= OWN_CPU;
              r_we    <= cpu_we;
              r_addr  <= cpu_addr & ~32'h3;
              r_wdata <= cpu_wdata;
              if (dbg_req && (r_starve_cnt != STARVE_MAX))
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!r_we) begin
              if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
              else                    r_dbg_rdata <= mem_rdata;
            end
            r_state <= DONE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            // A hung memory returns zero to whoever was waiting and is flagged forever.
            r_err <= 1'b1;
            if (r_owner == OWN_CPU) r_cpu_rdata <= '0;
            else                    r_dbg_rdata <= '0;
            r_state <= DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en    = (r_state == ACCESS);
  assign mem_we    = (r_state == ACCESS) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign cpu_stall = cpu_req && !((r_state == DONE) && (r_owner == OWN_CPU));
  assign dbg_ack   = (r_state == DONE) && (r_owner == OWN_DBG);
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: write/read latency, arbitration fairness,
// timeout, reset mid-access and address alignment.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, dbg_ack, mem_en, mem_we, err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    repeat (3) tick();
    total_cnt++; if ({mem_en, mem_we} !== 2'b00) $display("FAIL reset_mem_en_we got %b want 00", {mem_en, mem_we}); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); else pass_cnt++;
    total_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL reset_dbg_rdata got %h want 0", dbg_rdata); else pass_cnt++;
    total_cnt++; if ({dbg_ack, cpu_stall} !== 2'b00) $display("FAIL reset_ack_stall got %b want 00", {dbg_ack, cpu_stall}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write();
    int n = 0, en = 0, acks = 0;
    logic [31:0] a = 0, d = 0;
    logic w = 0;
    mem_ready = 1; cpu_we = 1; cpu_addr = 32'd100; cpu_wdata = 32'd25; cpu_req = 1;
    #1;
    while (cpu_stall && n < 20) begin
      n++;
      if (mem_en) begin en++; a = mem_addr; d = mem_wdata; w = mem_we; end
      if (dbg_ack) acks++;
      tick();
    end
    total_cnt++; if (n !== 2) $display("FAIL wr_stall_cycles got %0d want 2", n); else pass_cnt++;
    total_cnt++; if (en !== 1) $display("FAIL wr_mem_en_cycles got %0d want 1", en); else pass_cnt++;
    total_cnt++; if (a !== 32'd100) $display("FAIL wr_mem_addr got %0d want 100", a); else pass_cnt++;
    total_cnt++; if (d !== 32'd25) $display("FAIL wr_mem_wdata got %0d want 25", d); else pass_cnt++;
    total_cnt++; if (w !== 1'b1) $display("FAIL wr_mem_we got %b want 1", w); else pass_cnt++;
    total_cnt++; if ({mem_en, acks[0]} !== 2'b00) $display("FAIL wr_done_en_ack got %b want 00", {mem_en, acks[0]}); else pass_cnt++;
    cpu_req = 0;
    tick();
  endtask

  task automatic test_cpu_read();
    int n = 0, acc = 0;
    mem_ready = 0; mem_rdata = 32'hDEAD_BEEF;
    cpu_we = 0; cpu_addr = 32'd96; cpu_req = 1;
    #1;
    while (cpu_stall && n < 40) begin
      n++;
      if (mem_en) begin
        acc++;
        total_cnt++; if (mem_addr !== 32'd96) $display("FAIL rd_mem_addr got %0d want 96", mem_addr); else pass_cnt++;
        mem_ready = (acc == 4);
        mem_rdata = (acc == 4) ? 32'd7 : 32'hDEAD_BEEF;
      end else mem_ready = 0;
      tick();
    end
    total_cnt++; if (n !== 5) $display("FAIL rd_stall_cycles got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (acc !== 4) $display("FAIL rd_access_cycles got %0d want 4", acc); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 32'd7) $display("FAIL rd_cpu_rdata got %0d want 7", cpu_rdata); else pass_cnt++;
    cpu_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_unaligned();
    int n = 0;
    logic [31:0] a = 0;
    mem_ready = 1; mem_rdata = 32'h1111_1111;
    cpu_we = 1; cpu_addr = 32'd103; cpu_wdata = 32'h55; cpu_req = 1;
    #1;
    while (cpu_stall && n < 20) begin
      n++;
      if (mem_en) a = mem_addr;
      tick();
    end
    total_cnt++; if (a !== 32'd100) $display("FAIL unaligned_mem_addr got %0d want 100", a); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 32'd7) $display("FAIL write_keeps_cpu_rdata got %0d want 7", cpu_rdata); else pass_cnt++;
    cpu_req = 0;
    tick();
  endtask

  task automatic test_contention();
    int g = 0, cyc = 0, acks = 0;
    logic [9:0] pat = '0;
    mem_ready = 1; mem_rdata = 32'h0000_00A5;
    cpu_we = 0; cpu_addr = 32'h200; dbg_we = 0; dbg_addr = 32'h300;
    cpu_req = 1; dbg_req = 1;
    #1;
    while (g < 10 && cyc < 60) begin
      if (mem_en) begin pat[g] = (mem_addr == 32'h300); g++; end
      if (dbg_ack) acks++;
      tick();
      cyc++;
    end
    if (dbg_ack) acks++;
    total_cnt++; if (g !== 10) $display("FAIL contention_grants got %0d want 10", g); else pass_cnt++;
    total_cnt++; if (pat !== 10'b10_0001_0000) $display("FAIL contention_order got %b want 1000010000 (lsb first grant)", pat); else pass_cnt++;
    total_cnt++; if (acks !== 2) $display("FAIL contention_acks got %0d want 2", acks); else pass_cnt++;
    total_cnt++; if (dbg_rdata !== 32'hA5) $display("FAIL contention_dbg_rdata got %h want a5", dbg_rdata); else pass_cnt++;
    cpu_req = 0; dbg_req = 0;
    tick();
  endtask

  task automatic test_timeout();
    int acc = 0, cyc = 0;
    total_cnt++; if (err !== 1'b0) $display("FAIL err_before_timeout got %b want 0", err); else pass_cnt++;
    mem_ready = 0; mem_rdata = 32'h1234;
    dbg_we = 0; dbg_addr = 32'h40; dbg_req = 1;
    #1;
    while (!dbg_ack && cyc < 40) begin
      if (mem_en) acc++;
      tick();
      cyc++;
    end
    total_cnt++; if (dbg_ack !== 1'b1) $display("FAIL timeout_ack got %b want 1", dbg_ack); else pass_cnt++;
    total_cnt++; if (acc !== 16) $display("FAIL timeout_access_cycles got %0d want 16", acc); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL timeout_err got %b want 1", err); else pass_cnt++;
    total_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL timeout_dbg_rdata got %h want 0", dbg_rdata); else pass_cnt++;
    dbg_req = 0;
    tick();
    total_cnt++; if (dbg_ack !== 1'b0) $display("FAIL timeout_ack_single got %b want 0", dbg_ack); else pass_cnt++;
    mem_ready = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_req = 1;
    repeat (3) tick();
    cpu_req = 0;
    tick();
    total_cnt++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    int n = 0, en = 0, acks = 0;
    logic [31:0] a = 0;
    mem_ready = 0; mem_rdata = 32'h99;
    cpu_we = 0; cpu_addr = 32'h80; cpu_req = 1;
    tick();
    tick();
    total_cnt++; if (mem_en !== 1'b1) $display("FAIL rst_mid_in_access got %b want 1", mem_en); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (mem_en !== 1'b0) $display("FAIL rst_mid_mem_en got %b want 0", mem_en); else pass_cnt++;
    total_cnt++; if ({dbg_ack, err} !== 2'b00) $display("FAIL rst_mid_ack_err got %b want 00", {dbg_ack, err}); else pass_cnt++;
    total_cnt++; if (cpu_stall !== 1'b1) $display("FAIL rst_mid_stall got %b want 1", cpu_stall); else pass_cnt++;
    tick();
    reset = 1'b1;
    mem_ready = 1;
    #1;
    while (cpu_stall && n < 20) begin
      n++;
      if (mem_en) begin en++; a = mem_addr; end
      if (dbg_ack) acks++;
      tick();
    end
    total_cnt++; if (n !== 2) $display("FAIL rst_after_stall_cycles got %0d want 2", n); else pass_cnt++;
    total_cnt++; if (en !== 1 || a !== 32'h80) $display("FAIL rst_after_access got en=%0d addr=%h want 1/80", en, a); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 32'h99) $display("FAIL rst_after_cpu_rdata got %h want 99", cpu_rdata); else pass_cnt++;
    total_cnt++; if (acks !== 0) $display("FAIL rst_after_no_ack got %0d want 0", acks); else pass_cnt++;
    cpu_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_unaligned();
    test_contention();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
